// File: rtl/sw_input_conditioner_pkg.sv
// Shared board constants for the switch/pushbutton front end and the
// multicore wrapper that consumes its conditioned outputs.
package sw_input_conditioner_pkg;

    localparam int              SWC_WIDTH           = 5;
    localparam int              SWC_CNT_W           = 19;
    // 10 ms of stability at the 50 MHz board clock
    localparam int              SWC_DEBOUNCE_CYCLES = 500000;
    localparam logic [4:0]      SWC_ACTIVE_LOW_MASK = 5'b10000;
    localparam int              PB_IDX              = 4;

endpackage

// File: rtl/sw_input_conditioner_debounce_bit.sv
// One input bit: two-flop synchroniser, polarity fix, stability counter,
// accepted level and registered edge pulses.
module sw_debounce_bit
    import sw_input_conditioner_pkg::*;
#(
    parameter int   DEBOUNCE_CYCLES = SWC_DEBOUNCE_CYCLES,
    parameter int   CNT_W           = SWC_CNT_W,
    parameter logic ACTIVE_LOW      = 1'b0
) (
    input  logic Clock_pin,
    input  logic Resetn_pin,
    input  logic raw_bit,
    output logic clean_bit,
    output logic rise_bit,
    output logic fall_bit
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic             stable;
    logic [CNT_W-1:0] cnt;

    // Reset holds the idle pin level, which is 0 after polarity normalisation.
    always_ff @(posedge Clock_pin or negedge Resetn_pin) begin
        if (!Resetn_pin) begin
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            stable   <= 1'b0;
            cnt      <= '0;
            rise_bit <= 1'b0;
            fall_bit <= 1'b0;
        end else begin
            sync1    <= raw_bit ^ ACTIVE_LOW;
            sync2    <= sync1;
            rise_bit <= 1'b0;
            fall_bit <= 1'b0;
            if (sync2 == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                stable   <= sync2;
                cnt      <= '0;
                rise_bit <= sync2;
                fall_bit <= ~sync2;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign clean_bit = stable;

endmodule

// File: rtl/sw_input_conditioner.sv
// Conditions raw switch/pushbutton pins into clean active-high levels plus
// single-cycle rise/fall events, suppressed until the post-reset settle window.
module sw_input_conditioner
    import sw_input_conditioner_pkg::*;
#(
    parameter int                 WIDTH           = SWC_WIDTH,
    parameter int                 DEBOUNCE_CYCLES = SWC_DEBOUNCE_CYCLES,
    parameter int                 CNT_W           = SWC_CNT_W,
    parameter logic [WIDTH-1:0]   ACTIVE_LOW_MASK = WIDTH'(SWC_ACTIVE_LOW_MASK)
) (
    input  logic             Clock_pin,
    input  logic             Resetn_pin,
    input  logic [WIDTH-1:0] SW_raw,
    output logic [WIDTH-1:0] SW_clean,
    output logic [WIDTH-1:0] SW_rise,
    output logic [WIDTH-1:0] SW_fall,
    output logic             Settled
);

    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] bit_rise;
    logic [WIDTH-1:0] bit_fall;
    logic [CNT_W-1:0] settle_cnt;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        sw_debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W),
            .ACTIVE_LOW      (ACTIVE_LOW_MASK[i])
        ) u_bit (
            .Clock_pin  (Clock_pin),
            .Resetn_pin (Resetn_pin),
            .raw_bit    (SW_raw[i]),
            .clean_bit  (SW_clean[i]),
            .rise_bit   (bit_rise[i]),
            .fall_bit   (bit_fall[i])
        );
    end

    // Settle timer freezes once it fires; only reset re-arms it.
    always_ff @(posedge Clock_pin or negedge Resetn_pin) begin
        if (!Resetn_pin) begin
            settle_cnt <= '0;
            Settled    <= 1'b0;
        end else if (!Settled) begin
            if (settle_cnt == SETTLE_LAST) begin
                Settled <= 1'b1;
            end else begin
                settle_cnt <= settle_cnt + 1'b1;
            end
        end
    end

    // Levels always track; events are masked so power-up state is not an event.
    assign SW_rise = bit_rise & {WIDTH{Settled}};
    assign SW_fall = bit_fall & {WIDTH{Settled}};

endmodule
